// File: rtl/byte_ram_if.sv
// Write/read port bundle for byte_ram: one strobed write port, one read port.
// Latency: none (wires only); the read data/valid are registered inside byte_ram.
// Backpressure: ready low drops requests; there is no per-request stall.
// Ports: ready, wen/wstrb/waddr/wdata (write), ren/raddr (read), rdata/rvalid (response).
interface byte_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);

  logic                  ready;
  logic                  wen;
  logic [STRB_WIDTH-1:0] wstrb;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ren;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;

  // Requester side (load/store unit).
  modport master (
    input  ready,
    output wen, wstrb, waddr, wdata,
    output ren, raddr,
    input  rdata, rvalid
  );

  // Memory side.
  modport slave (
    output ready,
    input  wen, wstrb, waddr, wdata,
    input  ren, raddr,
    output rdata, rvalid
  );

endinterface

// File: rtl/byte_ram.sv
// Simple dual-port byte-strobed RAM with a zero-clear sequencer that runs after reset.
// Latency: read data and rvalid appear one cycle after ren; writes land on the request edge.
// Backpressure: none per request; while ready is low (clearing) all requests are dropped.
// Ports: clk, rst (sync, active-high); bus = byte_ram_if.slave
//   (ready out; wen/wstrb/waddr/wdata in; ren/raddr in; rdata/rvalid out).
module byte_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic       clk,
  input  logic       rst,
  byte_ram_if.slave  bus
);

  // Elaboration-time sanity checks on the geometry.
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("byte_ram: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("byte_ram: DEPTH must be at least 2");
  end

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  ready_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  // ---------------------------------------------------------------------------
  // Address range qualification. When DEPTH is a power of two every encodable
  // address is valid, so skip the compare entirely rather than build a
  // constant-true comparator.
  // ---------------------------------------------------------------------------
  logic waddr_ok;
  logic raddr_ok;

  if ((2 ** ADDR_WIDTH) == DEPTH) begin : g_pow2
    assign waddr_ok = 1'b1;
    assign raddr_ok = 1'b1;
  end else begin : g_npow2
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    assign waddr_ok = ({1'b0, bus.waddr} < DEPTH_EXT);
    assign raddr_ok = ({1'b0, bus.raddr} < DEPTH_EXT);
  end

  // Requests only count once the clear has finished.
  logic wr_en;
  logic rd_en;
  logic rw_hit;

  assign wr_en  = (state == READY) && bus.wen && waddr_ok;
  assign rd_en  = (state == READY) && bus.ren;
  // Same-edge read and write of one word. wr_en already implies the address
  // is in range, so a hit also implies the read address is in range.
  assign rw_hit = wr_en && (bus.waddr == bus.raddr);

  // ---------------------------------------------------------------------------
  // Read data selection: write-first per lane on a collision, zero for an
  // out-of-range address.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    if (raddr_ok) begin
      rd_word = mem[bus.raddr];
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (rw_hit && bus.wstrb[i]) begin
          rd_word[8*i +: 8] = bus.wdata[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs. Reset restarts the clear from word 0
  // regardless of where the sequencer or normal traffic was.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          // Requests arriving now are dropped, not queued.
          rvalid_q <= 1'b0;
          if (clr_addr == LAST_ADDR) begin
            state   <= READY;
            ready_q <= 1'b1;
          end else begin
            clr_addr <= clr_addr + ADDR_WIDTH'(1);
          end
        end
        READY: begin
          rvalid_q <= rd_en;
          // With no read the last data is held, not zeroed.
          if (rd_en) begin
            rdata_q <= rd_word;
          end
        end
        default: begin
          state    <= CLEAR;
          clr_addr <= '0;
          ready_q  <= 1'b0;
          rvalid_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. Kept free of reset so it maps onto block RAM; the clear
  // sequencer is what gives it defined contents.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_addr] <= '0;
      end else if (wr_en) begin
        for (int i = 0; i < STRB_WIDTH; i++) begin
          if (bus.wstrb[i]) begin
            mem[bus.waddr][8*i +: 8] <= bus.wdata[8*i +: 8];
          end
        end
      end
    end
  end

  assign bus.ready  = ready_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_byte_ram.sv
// Directed bench for byte_ram: an 8-word instance for clear, strobes,
// pipelining, collision and reset restart; a 6-word instance for out-of-range.
// Ports: none (top-level bench).
module tb_byte_ram;

  logic clk;
  logic rst8;
  logic rst6;

  int checks;
  int errors;

  byte_ram_if #(.DATA_WIDTH(32), .DEPTH(8)) b8 ();
  byte_ram_if #(.DATA_WIDTH(32), .DEPTH(6)) b6 ();

  byte_ram #(.DATA_WIDTH(32), .DEPTH(8)) u_dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (b8.slave)
  );

  byte_ram #(.DATA_WIDTH(32), .DEPTH(6)) u_dut6 (
    .clk (clk),
    .rst (rst6),
    .bus (b6.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle8();
    b8.wen   = 1'b0;
    b8.wstrb = '0;
    b8.waddr = '0;
    b8.wdata = '0;
    b8.ren   = 1'b0;
    b8.raddr = '0;
  endtask

  task automatic wr8(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    b8.wen = 1'b1; b8.waddr = a; b8.wdata = d; b8.wstrb = s;
    tick();
    b8.wen = 1'b0; b8.wstrb = '0;
  endtask

  task automatic rd8(input string tag, input logic [2:0] a, input logic [31:0] exp);
    b8.ren = 1'b1; b8.raddr = a;
    tick();
    b8.ren = 1'b0;
    check({tag, "_rvalid"}, 32'(b8.rvalid), 32'd1);
    check(tag, b8.rdata, exp);
  endtask

  // ready must stay low for DEPTH edges after release and rise after the last one.
  task automatic clear_seq8(input string tag);
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("%s_ready_e%0d", tag, k), 32'(b8.ready), (k == 7) ? 32'd1 : 32'd0);
      check($sformatf("%s_rvalid_e%0d", tag, k), 32'(b8.rvalid), 32'd0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle8();
    b6.wen = 1'b0; b6.wstrb = '0; b6.waddr = '0; b6.wdata = '0;
    b6.ren = 1'b0; b6.raddr = '0;
    rst8 = 1'b1;
    rst6 = 1'b1;

    // ---- Reset state and clear sequence (DEPTH=8) ----
    tick();
    tick();
    check("rst_ready", 32'(b8.ready), 32'd0);
    check("rst_rvalid", 32'(b8.rvalid), 32'd0);
    check("rst_rdata", b8.rdata, 32'h0);

    // Requests during the clear must be dropped.
    rst8 = 1'b0;
    b8.wen = 1'b1; b8.wstrb = 4'hF; b8.waddr = 3'd2; b8.wdata = 32'hFFFF_FFFF;
    b8.ren = 1'b1; b8.raddr = 3'd2;
    clear_seq8("clr");
    idle8();

    for (int a = 0; a < 8; a++) begin
      rd8($sformatf("clr_rd%0d", a), 3'(a), 32'h0);
    end

    // ---- Byte strobes ----
    wr8(3'd3, 32'hAABB_CCDD, 4'b1111);
    wr8(3'd3, 32'h1122_3344, 4'b0101);
    rd8("strb_mix", 3'd3, 32'hAA22_CC44);
    wr8(3'd3, 32'h0000_0000, 4'b0000);
    rd8("strb_none", 3'd3, 32'hAA22_CC44);

    // ---- Full-rate pipelined reads ----
    for (int a = 0; a < 4; a++) begin
      wr8(3'(a), 32'h10 + 32'(a), 4'hF);
    end
    for (int a = 0; a < 4; a++) begin
      b8.ren = 1'b1; b8.raddr = 3'(a);
      tick();
      check($sformatf("pipe_rvalid%0d", a), 32'(b8.rvalid), 32'd1);
      check($sformatf("pipe_rdata%0d", a), b8.rdata, 32'h10 + 32'(a));
    end
    b8.ren = 1'b0;
    tick();
    check("pipe_idle_rvalid", 32'(b8.rvalid), 32'd0);
    check("pipe_idle_hold", b8.rdata, 32'h13);

    // ---- Read-during-write collision ----
    wr8(3'd5, 32'h5566_7788, 4'hF);
    b8.wen = 1'b1; b8.wstrb = 4'b0011; b8.waddr = 3'd5; b8.wdata = 32'hDEAD_BEEF;
    b8.ren = 1'b1; b8.raddr = 3'd5;
    tick();
    b8.wen = 1'b0; b8.wstrb = '0;
    check("coll_rvalid", 32'(b8.rvalid), 32'd1);
    check("coll_fwd", b8.rdata, 32'h5566_BEEF);
    tick();
    b8.ren = 1'b0;
    check("coll_after", b8.rdata, 32'h5566_BEEF);

    // Different addresses on the same edge are independent.
    b8.wen = 1'b1; b8.wstrb = 4'hF; b8.waddr = 3'd4; b8.wdata = 32'h0000_0099;
    b8.ren = 1'b1; b8.raddr = 3'd5;
    tick();
    idle8();
    check("diff_rd", b8.rdata, 32'h5566_BEEF);
    rd8("diff_wr", 3'd4, 32'h0000_0099);

    // ---- Reset mid-operation, then again mid-clear ----
    wr8(3'd6, 32'h1234_5678, 4'hF);
    rd8("rst_pre", 3'd6, 32'h1234_5678);
    check("rst_pre_ready", 32'(b8.ready), 32'd1);
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
    tick();
    tick();
    tick();
    check("rst_midclr_ready", 32'(b8.ready), 32'd0);
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
    check("rst2_rdata", b8.rdata, 32'h0);
    check("rst2_ready", 32'(b8.ready), 32'd0);
    clear_seq8("reclr");
    rd8("reclr_rd6", 3'd6, 32'h0);

    // ---- Non-power-of-two depth (DEPTH=6) ----
    rst6 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("d6_ready_e%0d", k), 32'(b6.ready), (k == 5) ? 32'd1 : 32'd0);
    end
    b6.wen = 1'b1; b6.wstrb = 4'hF; b6.waddr = 3'd7; b6.wdata = 32'hFFFF_FFFF;
    tick();
    b6.waddr = 3'd0; b6.wdata = 32'hCAFE_F00D;
    tick();
    b6.wen = 1'b0; b6.wstrb = '0;
    for (int a = 0; a < 6; a++) begin
      b6.ren = 1'b1; b6.raddr = 3'(a);
      tick();
      check($sformatf("d6_rvalid%0d", a), 32'(b6.rvalid), 32'd1);
      check($sformatf("d6_rd%0d", a), b6.rdata, (a == 0) ? 32'hCAFE_F00D : 32'h0);
    end
    // rdata is nonzero going in, so a zero here is the out-of-range response.
    b6.ren = 1'b1; b6.raddr = 3'd0;
    tick();
    b6.raddr = 3'd7;
    tick();
    check("d6_oor_rvalid", 32'(b6.rvalid), 32'd1);
    check("d6_oor_rdata", b6.rdata, 32'h0);
    // Out-of-range read colliding with out-of-range write: no forwarding.
    b6.raddr = 3'd0;
    tick();
    b6.wen = 1'b1; b6.wstrb = 4'hF; b6.waddr = 3'd7; b6.wdata = 32'h1234_5678;
    b6.raddr = 3'd7;
    tick();
    b6.wen = 1'b0; b6.wstrb = '0; b6.ren = 1'b0;
    check("d6_oor_coll_rvalid", 32'(b6.rvalid), 32'd1);
    check("d6_oor_coll_rdata", b6.rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
